seg7_pattern_encoder: RTL and testbench
=======================================

// Module: seg7_pattern_encoder
// PURPOSE
//  Inverse of the 2-bit -> 7-segment decoder. Samples a 7-bit segment bus and
//  debounces it: a pattern is accepted only after STABLE_CYCLES unchanged cycles.
//  Each accepted change is encoded back to its 2-bit code and offered on a
//  valid/ready output. Sits between a segment-driving source (or loopback of
//  the display bus) and CPU-side logic; counts illegal patterns.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples needed to accept (>=1)
//  ERR_W          8  width of saturating invalid-pattern counter
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  seg_in       in   7      segment pattern bus, bit6..bit0
//  code         out  2      encoded code, valid while code_valid=1
//  code_valid   out  1      code offered to consumer
//  code_ready   in   1      consumer accepts code this cycle
//  blank        out  1      last accepted pattern was all-off (7'b0000000)
//  invalid_cnt  out  ERR_W  saturating count of accepted illegal patterns
//  overrun      out  1      sticky: accepted code dropped, output slot full
//  clear_err    in   1      clears invalid_cnt and overrun
// BEHAVIOUR
//  Legal map: 7'b0000111->2'b00, 7'b1110000->2'b01, 7'b0011100->2'b10,
//   7'b1100011->2'b11. 7'b0000000 = blank. Any other pattern = illegal.
//  Reset: cand=7'b0, stab_cnt=0, acc=7'b0, code=2'b00, code_valid=0, blank=1,
//   invalid_cnt=0, overrun=0. Pending output is discarded.
//  Stability filter, each edge:
//   - seg_in != cand: cand<=seg_in, stab_cnt<=1.
//   - else if stab_cnt<STABLE_CYCLES: stab_cnt<=stab_cnt+1 (saturates).
//  Accept: when stab_cnt==STABLE_CYCLES and cand!=acc, at that edge acc<=cand.
//  Latency: seg_in first sampled at edge N -> acceptance effects after edge
//   N+STABLE_CYCLES. Glitches shorter than STABLE_CYCLES are ignored.
//   Return to acc after a glitch does not re-emit.
//  On acceptance:
//   - Legal: blank<=0. If slot free (!code_valid || code_ready): code<=enc,
//     code_valid<=1. Otherwise held code is kept and overrun<=1.
//   - Blank: blank<=1, no emission.
//   - Illegal: blank<=0, invalid_cnt+1, saturating at all-ones. No emission.
//  Handshake: code and code_valid are held stable while code_valid && !code_ready.
//   Transfer occurs at an edge with both high. code_valid then drops next cycle,
//   unless a legal acceptance occurs at the same edge (reload, no overrun).
//  clear_err has priority over a same-cycle increment or overrun set.
//  P -> blank -> P (each stable) emits P twice.
// TESTING (STABLE_CYCLES=4 unless noted)
//  1 reset, seg_in=7'b0 for 10 cyc -> code_valid=0, blank=1, invalid_cnt=0.
//  2 seg_in=7'b1110000 held, code_ready=1 -> code_valid high exactly 1 cyc,
//    after edge N+4 (N = first sampling edge), code=2'b01, blank=0.
//  3 seg_in=7'b0011100 for 3 cyc, then 7'b1100011 held -> only 2'b11 emitted.
//  4 code_ready=0: 7'b0000111 stable, then 7'b0011100 stable -> code=2'b00
//    held valid, overrun=1. Raise code_ready -> one transfer of 2'b00.
//  5 seg_in=7'b1111111 stable -> invalid_cnt=1, no valid. With ERR_W=2,
//    5 illegal patterns separated by blank -> invalid_cnt=3. clear_err -> 0.
//  6 reset asserted with code_valid=1, code_ready=0 -> after the edge:
//    code_valid=0, overrun=0, blank=1, and the code is not re-emitted.

Source files
------------

// File: rtl/seg7_pattern_encoder.sv
// Debounces a 7-segment bus and encodes each newly accepted pattern back to its
// 2-bit code, offered on a valid/ready port; illegal patterns are counted.
module seg7_pattern_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [1:0]       code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             blank,
    output logic [ERR_W-1:0] invalid_cnt,
    output logic             overrun,
    input  logic             clear_err
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       acc_q, acc_d;
    logic [1:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic [ERR_W-1:0] inv_q, inv_d;
    logic             ovr_q, ovr_d;

    logic       accept;
    logic       isLegal;
    logic       isBlank;
    logic [1:0] enc;
    logic       incErr;
    logic       setOvr;

    always_comb begin
        isLegal = 1'b1;
        enc     = 2'b00;
        case (cand_q)
            7'b0000111: enc = 2'b00;
            7'b1110000: enc = 2'b01;
            7'b0011100: enc = 2'b10;
            7'b1100011: enc = 2'b11;
            default:    isLegal = 1'b0;
        endcase
        isBlank = (cand_q == 7'b0000000);
    end

    // A new sample restarts the run length; an unchanged one extends it up to the threshold.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (seg_in != cand_q) begin
            cand_d = seg_in;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign accept = (cnt_q == CNT_MAX) && (cand_q != acc_q);

    always_comb begin
        acc_d   = acc_q;
        code_d  = code_q;
        valid_d = valid_q;
        blank_d = blank_q;
        inv_d   = inv_q;
        ovr_d   = ovr_q;
        incErr  = 1'b0;
        setOvr  = 1'b0;

        if (valid_q && code_ready) begin
            valid_d = 1'b0;
        end

        // A completed transfer frees the slot in the same cycle, so a legal code can reload it.
        if (accept) begin
            acc_d = cand_q;
            if (isBlank) begin
                blank_d = 1'b1;
            end else begin
                blank_d = 1'b0;
                if (isLegal) begin
                    if (!valid_q || code_ready) begin
                        code_d  = enc;
                        valid_d = 1'b1;
                    end else begin
                        setOvr = 1'b1;
                    end
                end else begin
                    incErr = 1'b1;
                end
            end
        end

        if (clear_err) begin
            inv_d = '0;
            ovr_d = 1'b0;
        end else begin
            if (incErr && (inv_q != {ERR_W{1'b1}})) begin
                inv_d = inv_q + 1'b1;
            end
            if (setOvr) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= 7'b0000000;
            cnt_q   <= '0;
            acc_q   <= 7'b0000000;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            blank_q <= 1'b1;
            inv_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            inv_q   <= inv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign code        = code_q;
    assign code_valid  = valid_q;
    assign blank       = blank_q;
    assign invalid_cnt = inv_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_pattern_encoder.sv
// Bench for seg7_pattern_encoder: hand sequences, a vector table and randomized
// traffic compared every cycle against a sample-history reference model.
module tb_seg7_pattern_encoder;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg_in = 7'b0;
    logic       code_ready = 1'b0;
    logic       clear_err = 1'b0;

    logic [1:0] code, code2;
    logic       code_valid, code_valid2;
    logic       blank, blank2;
    logic [7:0] invalid_cnt;
    logic [1:0] invalid_cnt2;
    logic       overrun, overrun2;

    int checks = 0;
    int errors = 0;
    bit modelChk = 1'b0;

    always #5 clk = ~clk;

    seg7_pattern_encoder #(.STABLE_CYCLES(SC), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .code(code),
        .code_valid(code_valid), .code_ready(code_ready), .blank(blank),
        .invalid_cnt(invalid_cnt), .overrun(overrun), .clear_err(clear_err)
    );

    seg7_pattern_encoder #(.STABLE_CYCLES(SC), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .seg_in(seg_in), .code(code2),
        .code_valid(code_valid2), .code_ready(code_ready), .blank(blank2),
        .invalid_cnt(invalid_cnt2), .overrun(overrun2), .clear_err(clear_err)
    );

    // Reference model: a pattern is accepted once the last SC samples all agree
    // and differ from the previously accepted pattern.
    logic [6:0] hist[$];
    logic [6:0] mAcc;
    logic [1:0] mCode;
    bit         mValid, mBlank, mOvr;
    int         mInv, mInv2;

    function automatic int encodeOf(input logic [6:0] p);
        case (p)
            7'b0000111: return 0;
            7'b1110000: return 1;
            7'b0011100: return 2;
            7'b1100011: return 3;
            default:    return -1;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit         stable;
        bit         slotFree;
        bit         incE;
        bit         setO;
        logic [6:0] v;
        int         e;
        if (reset) begin
            hist.delete();
            mAcc = 7'b0; mCode = 2'b00; mValid = 1'b0; mBlank = 1'b1;
            mInv = 0; mInv2 = 0; mOvr = 1'b0;
        end else begin
            stable = (hist.size() >= SC);
            v = stable ? hist[hist.size()-1] : 7'b0;
            if (stable)
                for (int k = 0; k < SC; k++)
                    if (hist[hist.size()-1-k] != v) stable = 1'b0;
            slotFree = !mValid || code_ready;
            if (mValid && code_ready) mValid = 1'b0;
            incE = 1'b0;
            setO = 1'b0;
            if (stable && v != mAcc) begin
                mAcc = v;
                e = encodeOf(v);
                if (v == 7'b0) mBlank = 1'b1;
                else begin
                    mBlank = 1'b0;
                    if (e >= 0) begin
                        if (slotFree) begin
                            mCode = 2'(e);
                            mValid = 1'b1;
                        end else setO = 1'b1;
                    end else incE = 1'b1;
                end
            end
            if (clear_err) begin
                mInv = 0; mInv2 = 0; mOvr = 1'b0;
            end else begin
                if (incE) begin
                    if (mInv < 255) mInv++;
                    if (mInv2 < 3) mInv2++;
                end
                if (setO) mOvr = 1'b1;
            end
            hist.push_back(seg_in);
            if (hist.size() > SC) void'(hist.pop_front());
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("model.valid", 32'(code_valid), 32'(mValid));
        checkVal("model.code", 32'(code), 32'(mCode));
        checkVal("model.blank", 32'(blank), 32'(mBlank));
        checkVal("model.invalid", 32'(invalid_cnt), 32'(mInv));
        checkVal("model.invalid2", 32'(invalid_cnt2), 32'(mInv2));
        checkVal("model.overrun", 32'(overrun), 32'(mOvr));
        checkVal("model.valid2", 32'(code_valid2), 32'(mValid));
    endtask

    always @(negedge clk) begin
        if (modelChk) checkOutput();
    end

    // Drives inputs at a falling edge and waits n rising edges.
    task automatic applyStimulus(input logic [6:0] s, input logic rdy, input logic clr, input int n);
        seg_in = s;
        code_ready = rdy;
        clear_err = clr;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(7'b0, 1'b1, 1'b0, 1);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [1:0] expCode;
        logic       expBlank;
        int         expInv;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int cnt;
        int xfers;
        logic [1:0] lastCode;
        logic [6:0] pat;
        logic [6:0] legal[4];

        vecs[0] = '{7'b0000111, 2'b00, 1'b0, 0};
        vecs[1] = '{7'b1111111, 2'b00, 1'b0, 1};
        vecs[2] = '{7'b0000000, 2'b00, 1'b1, 1};
        vecs[3] = '{7'b1110000, 2'b01, 1'b0, 1};
        vecs[4] = '{7'b1010101, 2'b01, 1'b0, 2};
        vecs[5] = '{7'b0011100, 2'b10, 1'b0, 2};
        vecs[6] = '{7'b1100011, 2'b11, 1'b0, 2};
        vecs[7] = '{7'b0000000, 2'b11, 1'b1, 2};
        vecs[8] = '{7'b1100011, 2'b11, 1'b0, 2};
        legal[0] = 7'b0000111; legal[1] = 7'b1110000;
        legal[2] = 7'b0011100; legal[3] = 7'b1100011;

        @(negedge clk);
        doReset();
        modelChk = 1'b1;

        applyStimulus(7'b0, 1'b1, 1'b0, 10);
        checkVal("reset.valid", 32'(code_valid), 0);
        checkVal("reset.blank", 32'(blank), 1);
        checkVal("reset.invalid", 32'(invalid_cnt), 0);

        applyStimulus(7'b1110000, 1'b1, 1'b0, SC);
        checkVal("latency.early_valid", 32'(code_valid), 0);
        applyStimulus(7'b1110000, 1'b1, 1'b0, 1);
        checkVal("latency.valid", 32'(code_valid), 1);
        checkVal("latency.code", 32'(code), 1);
        checkVal("latency.blank", 32'(blank), 0);
        applyStimulus(7'b1110000, 1'b1, 1'b0, 1);
        checkVal("latency.drop", 32'(code_valid), 0);

        cnt = 0;
        lastCode = 2'b00;
        for (int i = 0; i < 13; i++) begin
            applyStimulus((i < 3) ? 7'b0011100 : 7'b1100011, 1'b1, 1'b0, 1);
            if (code_valid) begin
                cnt++;
                lastCode = code;
            end
        end
        checkVal("glitch.emits", 32'(cnt), 1);
        checkVal("glitch.code", 32'(lastCode), 3);

        applyStimulus(7'b0000111, 1'b0, 1'b0, 6);
        checkVal("hold.valid", 32'(code_valid), 1);
        checkVal("hold.code", 32'(code), 0);
        checkVal("hold.overrun0", 32'(overrun), 0);
        applyStimulus(7'b0011100, 1'b0, 1'b0, 6);
        checkVal("hold.valid_kept", 32'(code_valid), 1);
        checkVal("hold.code_kept", 32'(code), 0);
        checkVal("hold.overrun1", 32'(overrun), 1);
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            code_ready = 1'b1;
            if (code_valid) begin
                xfers++;
                lastCode = code;
            end
            applyStimulus(7'b0011100, 1'b1, 1'b0, 1);
        end
        checkVal("hold.transfers", 32'(xfers), 1);
        checkVal("hold.xfer_code", 32'(lastCode), 0);
        applyStimulus(7'b0011100, 1'b1, 1'b1, 1);
        checkVal("hold.clear_ovr", 32'(overrun), 0);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].seg, 1'b1, 1'b0, 6);
            checkVal($sformatf("vec%0d.valid", i), 32'(code_valid), 0);
            checkVal($sformatf("vec%0d.code", i), 32'(code), 32'(vecs[i].expCode));
            checkVal($sformatf("vec%0d.blank", i), 32'(blank), 32'(vecs[i].expBlank));
            checkVal($sformatf("vec%0d.invalid", i), 32'(invalid_cnt), 32'(vecs[i].expInv));
            checkVal($sformatf("vec%0d.overrun", i), 32'(overrun), 0);
        end

        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(7'b1111111, 1'b1, 1'b0, 6);
            if (i == 0) checkVal("sat.first", 32'(invalid_cnt), 1);
            checkVal("sat.no_valid", 32'(code_valid), 0);
            applyStimulus(7'b0000000, 1'b1, 1'b0, 6);
        end
        checkVal("sat.w8", 32'(invalid_cnt), 5);
        checkVal("sat.w2", 32'(invalid_cnt2), 3);
        applyStimulus(7'b0000000, 1'b1, 1'b1, 1);
        checkVal("sat.clear8", 32'(invalid_cnt), 0);
        checkVal("sat.clear2", 32'(invalid_cnt2), 0);

        applyStimulus(7'b1110000, 1'b0, 1'b0, 6);
        applyStimulus(7'b0000111, 1'b0, 1'b0, 6);
        checkVal("rst.pre_valid", 32'(code_valid), 1);
        checkVal("rst.pre_ovr", 32'(overrun), 1);
        doReset();
        checkVal("rst.valid", 32'(code_valid), 0);
        checkVal("rst.overrun", 32'(overrun), 0);
        checkVal("rst.blank", 32'(blank), 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(7'b0, 1'b0, 1'b0, 1);
            if (code_valid) cnt++;
        end
        checkVal("rst.no_reemit", 32'(cnt), 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: pat = legal[$urandom_range(0, 3)];
                3:       pat = 7'b0;
                default: pat = 7'($urandom);
            endcase
            if ($urandom_range(0, 60) == 0) begin
                doReset();
            end else begin
                applyStimulus(pat, 1'($urandom_range(0, 9) < 7),
                              1'($urandom_range(0, 29) == 0), $urandom_range(1, 6));
            end
        end

        modelChk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
